bp_be_fe_queue_thread_buffer: RTL

//  Per-thread FE->BE instruction queue between the front end and the back-end top's fe_queue_i/v_i/ready_and_o port.
//  FE pushes fetch packets tagged with a thread ID. The BE pops only from the queue of the thread selected by the thread scheduler that cycle.
//  A redirect or context flush clears one thread's queue without disturbing the others.

---
 rtl/bp_be_fe_queue_thread_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/bp_be_fe_queue_thread_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_fe_queue_thread_buffer
// Brief    : Per-thread FE->BE instruction queues; FE pushes tagged packets,
//            BE pops from the scheduled thread, flush clears a single thread.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_fe_queue_thread_buffer #(
    parameter int num_threads_p     = 2,
    parameter int thread_id_width_p = 1,
    parameter int entry_width_p     = 64,
    parameter int els_p             = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [entry_width_p-1:0]     fe_queue_i,
    input  logic [thread_id_width_p-1:0] fe_queue_thread_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_and_o,
    input  logic [thread_id_width_p-1:0] thread_id_i,
    output logic [entry_width_p-1:0]     be_queue_o,
    output logic                         be_queue_v_o,
    input  logic                         be_queue_ready_and_i,
    input  logic                         flush_v_i,
    input  logic [thread_id_width_p-1:0] flush_thread_i,
    output logic [num_threads_p-1:0]     empty_o,
    output logic [num_threads_p-1:0]     full_o
);

    localparam int c_ptr_w = $clog2(els_p);
    localparam int c_cnt_w = $clog2(els_p + 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(els_p);

    logic [num_threads_p-1:0]                    w_enq_sel;
    logic [num_threads_p-1:0]                    w_deq_sel;
    logic [num_threads_p-1:0]                    w_flush;
    logic [num_threads_p-1:0]                    w_empty;
    logic [num_threads_p-1:0]                    w_full;
    logic [num_threads_p-1:0]                    w_enq;
    logic [num_threads_p-1:0]                    w_deq;
    logic [num_threads_p-1:0][entry_width_p-1:0] w_head;

`ifndef SYNTHESIS
    generate
        if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
            $error("els_p must be a power of 2 and at least 2");
        end
    endgenerate
`endif

    // Out-of-range thread IDs match no decode bit, so they are never ready/valid and flush nothing.
    generate
        for (genvar t = 0; t < num_threads_p; t++) begin : g_thread
            localparam logic [thread_id_width_p-1:0] c_tid = thread_id_width_p'(t);

            logic [entry_width_p-1:0] r_mem [els_p];
            logic [c_ptr_w-1:0]       r_rd_ptr;
            logic [c_ptr_w-1:0]       r_wr_ptr;
            logic [c_cnt_w-1:0]       r_count;

            assign w_enq_sel[t] = (fe_queue_thread_i == c_tid);
            assign w_deq_sel[t] = (thread_id_i == c_tid);
            assign w_flush[t]   = flush_v_i & (flush_thread_i == c_tid);
            assign w_empty[t]   = (r_count == '0);
            assign w_full[t]    = (r_count == c_full_cnt);
            assign w_enq[t]     = fe_queue_v_i & w_enq_sel[t] & ~w_full[t] & ~w_flush[t];
            assign w_deq[t]     = be_queue_ready_and_i & w_deq_sel[t] & ~w_empty[t] & ~w_flush[t];
            assign w_head[t]    = r_mem[r_rd_ptr];

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else if (w_flush[t]) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_enq[t]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_deq[t]) r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (w_enq[t] && !w_deq[t]) r_count <= r_count + 1'b1;
                    else if (!w_enq[t] && w_deq[t]) r_count <= r_count - 1'b1;
                end
            end

            // Entry storage carries no reset; contents are only observed through valid.
            always_ff @(posedge clk_i) begin
                if (w_enq[t]) r_mem[r_wr_ptr] <= fe_queue_i;
            end

`ifndef SYNTHESIS
            a_no_enq_full : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                !(w_enq[t] && w_full[t]));
            a_no_deq_empty : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                !(w_deq[t] && w_empty[t]));
`endif
        end
    endgenerate

    always_comb begin
        be_queue_o = '0;
        for (int i = 0; i < num_threads_p; i++) begin
            if (w_deq_sel[i]) be_queue_o = w_head[i];
        end
    end

    assign be_queue_v_o         = |(w_deq_sel & ~w_empty & ~w_flush);
    assign fe_queue_ready_and_o = |(w_enq_sel & ~w_full & ~w_flush);
    assign empty_o              = w_empty;
    assign full_o               = w_full;

endmodule
`default_nettype wire
